// File: rtl/lojik_pkg.sv
// Shared types and constants for the lab gate checker.
package lojik_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VEC = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Counts the cycles a vector has been held; expired marks the last WAIT cycle.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      cnt <= 4'd0;
    end else if (enable) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expired = (cnt == 4'(SETTLE - 1));

endmodule

// File: rtl/gate_check_ctrl.sv
// Sequencer that sweeps a 2-input gate through all four input vectors
// and scores each sampled output against a latched truth table.
module gate_check_ctrl
  import lojik_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_truth,
  output logic       o_a,
  output logic       o_b,
  input  logic       i_gate_o,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [2:0] o_err_cnt,
  output logic [3:0] o_err_mask
);

  state_t     state, next_state;
  logic [1:0] idx;
  logic [3:0] truth_q;
  logic       expired;
  logic       mismatch;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (state != WAIT),
    .enable  ((state == WAIT) && !expired),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = WAIT;
      WAIT:    if (expired) next_state = SAMPLE;
      SAMPLE:  next_state = (idx == 2'(NUM_VEC - 1)) ? DONE : WAIT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mismatch = (i_gate_o != truth_q[idx]);

  // Pass is decided on the final SAMPLE edge so it is valid alongside o_done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx        <= 2'd0;
      truth_q    <= 4'd0;
      o_err_cnt  <= 3'd0;
      o_err_mask <= 4'd0;
      o_pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            idx        <= 2'd0;
            truth_q    <= i_truth;
            o_err_cnt  <= 3'd0;
            o_err_mask <= 4'd0;
            o_pass     <= 1'b0;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            o_err_mask[idx] <= 1'b1;
            o_err_cnt       <= o_err_cnt + 3'd1;
          end
          if (idx == 2'(NUM_VEC - 1)) begin
            o_pass <= (o_err_cnt == 3'd0) && !mismatch;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy = (state == WAIT) || (state == SAMPLE);
    o_done = (state == DONE);
    o_a    = o_busy ? idx[1] : 1'b0;
    o_b    = o_busy ? idx[0] : 1'b0;
  end

endmodule

// File: tb/tb_gate_check_ctrl.sv
// Bench for gate_check_ctrl: two instances (SETTLE 2 and 1) each driving a
// behavioural gate; results are predicted from truth tables and timing rules.
module tb_gate_check_ctrl;
  import lojik_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [2];
  logic [3:0] truth    [2];
  logic [3:0] gate_tt  [2];
  logic       a        [2];
  logic       b        [2];
  logic       gate_o   [2];
  logic       busy     [2];
  logic       done     [2];
  logic       pass     [2];
  logic [2:0] err_cnt  [2];
  logic [3:0] err_mask [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign gate_o[0] = gate_tt[0][{a[0], b[0]}];
  assign gate_o[1] = gate_tt[1][{a[1], b[1]}];

  gate_check_ctrl #(.SETTLE(2)) u_dut_s2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_truth(truth[0]),
    .o_a(a[0]), .o_b(b[0]), .i_gate_o(gate_o[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_pass(pass[0]), .o_err_cnt(err_cnt[0]),
    .o_err_mask(err_mask[0])
  );

  gate_check_ctrl #(.SETTLE(1)) u_dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_truth(truth[1]),
    .o_a(a[1]), .o_b(b[1]), .i_gate_o(gate_o[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_pass(pass[1]), .o_err_cnt(err_cnt[1]),
    .o_err_mask(err_mask[1])
  );

  typedef struct {
    int         sel;
    logic [3:0] truth;
    logic [3:0] gate;
    logic [3:0] exp_mask;
    logic [2:0] exp_cnt;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[6];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Static gate: a mismatch is exactly a differing truth-table bit.
  task automatic model(input logic [3:0] tt, input logic [3:0] gtt,
                       output logic [3:0] mask, output logic [2:0] cnt,
                       output logic ok);
    mask = tt ^ gtt;
    cnt  = 3'd0;
    for (int i = 0; i < 4; i++) cnt = cnt + 3'(mask[i]);
    ok = (cnt == 3'd0);
  endtask

  task automatic check_idle_zero(input int sel, input string name);
    check_output(name, {busy[sel], done[sel], a[sel], b[sel], pass[sel],
                        err_cnt[sel], err_mask[sel]}, 32'd0);
  endtask

  // One-cycle start, then cycle-by-cycle timeline and final result checks.
  task automatic apply_stimulus(input int sel, input logic [3:0] tt,
                                input logic [3:0] gtt, input logic [3:0] exp_mask,
                                input logic [2:0] exp_cnt, input logic exp_pass,
                                input bit disturb);
    int per;
    int last;
    logic [3:0] exp_tl;
    per  = (sel == 0) ? 3 : 2;
    last = 4 * per + 1;
    truth[sel]   = tt;
    gate_tt[sel] = gtt;
    start[sel]   = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    for (int c = 1; c <= last; c++) begin
      exp_tl[3] = (c <= 4 * per);
      exp_tl[2] = (c == last);
      exp_tl[1:0] = exp_tl[3] ? 2'((c - 1) / per) : 2'd0;
      check_output($sformatf("timeline s%0d c%0d", sel, c),
                   {28'd0, busy[sel], done[sel], a[sel], b[sel]}, {28'd0, exp_tl});
      if (c == last) begin
        check_output("err_mask", {28'd0, err_mask[sel]}, {28'd0, exp_mask});
        check_output("err_cnt", {29'd0, err_cnt[sel]}, {29'd0, exp_cnt});
        check_output("pass", {31'd0, pass[sel]}, {31'd0, exp_pass});
      end
      if (disturb && c == 3) truth[sel] = 4'b0000;
      start[sel] = disturb && (c == 5);
      @(negedge clk);
    end
    check_output("held result", {27'd0, pass[sel], err_cnt[sel], done[sel]},
                 {27'd0, exp_pass, exp_cnt, 1'b0});
  endtask

  initial begin
    logic [3:0] m;
    logic [2:0] n;
    logic       p;
    logic [3:0] rt;
    logic [3:0] rg;
    int         rs;
    bit         saw_done;

    tbl[0] = '{0, TT_AND,  TT_AND,  4'b0000, 3'd0, 1'b1};
    tbl[1] = '{0, TT_OR,   TT_AND,  4'b0110, 3'd2, 1'b0};
    tbl[2] = '{1, TT_AND,  TT_AND,  4'b0000, 3'd0, 1'b1};
    tbl[3] = '{0, TT_NAND, TT_XOR,  4'b0001, 3'd1, 1'b0};
    tbl[4] = '{1, TT_AND,  TT_NAND, 4'b1111, 3'd4, 1'b0};
    tbl[5] = '{1, TT_XOR,  TT_OR,   4'b1000, 3'd1, 1'b0};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; truth[s] = 4'd0; gate_tt[s] = TT_AND;
    end
    repeat (3) @(negedge clk);
    check_idle_zero(0, "reset s2");
    check_idle_zero(1, "reset s1");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].sel, tbl[i].truth, tbl[i].gate, tbl[i].exp_mask,
                     tbl[i].exp_cnt, tbl[i].exp_pass, 1'b0);
    end

    // OR gate: truth altered and start re-pulsed mid-run must not matter
    apply_stimulus(0, TT_OR, TT_OR, 4'b0000, 3'd0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rs = int'($urandom_range(0, 1));
      rt = 4'($urandom);
      rg = 4'($urandom);
      model(rt, rg, m, n, p);
      apply_stimulus(rs, rt, rg, m, n, p, 1'b0);
    end

    // Start held high: back-to-back runs with a 14-cycle period
    truth[0] = TT_AND; gate_tt[0] = TT_AND; start[0] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      check_output($sformatf("held start c%0d", c), {30'd0, busy[0], done[0]},
                   {30'd0, ((c - 1) % 14) < 12, ((c - 1) % 14) == 12});
      @(negedge clk);
    end
    start[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero(0, "reset after held start");

    // Reset during WAIT of vector 10
    truth[0] = TT_AND; gate_tt[0] = TT_AND; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    check_output("vector before reset", {29'd0, busy[0], a[0], b[0]}, 32'b110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero(0, "mid-run reset");
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (done[0] || busy[0]) saw_done = 1'b1;
      @(negedge clk);
    end
    check_output("no done after reset", {31'd0, saw_done}, 32'd0);
    apply_stimulus(0, TT_AND, TT_AND, 4'b0000, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
